// File: rtl/dac_stream_pacer.sv
// Paced DAC sample streamer: FIFO buffer, prime threshold, and a period counter that pops one sample per tick.
// Optional macro DAC_STREAM_PACER_SIGNED_IN_EN converts two's-complement input to offset binary at the pop.
module dac_stream_pacer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int PRIME_LEVEL = 8,
  parameter int IDLE_LEVEL  = 8192
) (
  input  logic        CLK_65,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] divisor,
  input  logic        clear_flags,
  input  logic [13:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [13:0] dac_data,
  output logic        dac_valid,
  output logic        underrun,
  output logic [8:0]  fill_level
);

  // state   | meaning
  // S_IDLE  | disabled, outputs held, FIFO retained
  // S_PRIME | waiting for PRIME_LEVEL samples
  // S_RUN   | period counter running, one pop per tick
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam logic [8:0]     DEPTH_L = 9'(FIFO_DEPTH);
  localparam logic [8:0]     PRIME_L = 9'(PRIME_LEVEL);
  localparam logic [13:0]    IDLE_L  = 14'(IDLE_LEVEL);
  localparam logic [AW-1:0]  PTR_ONE = AW'(1);

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [8:0]      r_fill;
  logic [15:0]     r_cnt;
  logic [15:0]     r_div_eff;
  logic [13:0]     r_mem [FIFO_DEPTH];
  logic [13:0]     r_dac_data;
  logic            r_dac_valid;
  logic            r_underrun;
  logic            r_s_ready;

  logic [15:0]     w_div_in;
  logic            w_push;
  logic            w_tick;
  logic            w_pop;
  logic            w_starve;
  logic [8:0]      w_fill_nxt;
  logic [13:0]     w_head;

  assign w_div_in   = (divisor == 16'd0) ? 16'd1 : divisor;
  assign w_push     = s_valid && r_s_ready;
  assign w_tick     = (r_state == S_RUN) && enable && (r_cnt == r_div_eff - 16'd1);
  assign w_pop      = w_tick && (r_fill != 9'd0);
  // a write landing in the same cycle cannot satisfy a read due on an empty FIFO
  assign w_starve   = w_tick && (r_fill == 9'd0);
  assign w_fill_nxt = r_fill + 9'(w_push) - 9'(w_pop);

`ifdef DAC_STREAM_PACER_SIGNED_IN_EN
  assign w_head = r_mem[r_rd_ptr] ^ 14'h2000;
`else
  assign w_head = r_mem[r_rd_ptr];
`endif

  always_ff @(posedge CLK_65) begin
    if (w_push) r_mem[r_wr_ptr] <= s_data;
  end

  always_ff @(posedge CLK_65 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_cnt       <= '0;
      r_div_eff   <= 16'd1;
      r_dac_data  <= IDLE_L;
      r_dac_valid <= 1'b0;
      r_underrun  <= 1'b0;
      r_s_ready   <= 1'b0;
    end else begin
      r_fill      <= w_fill_nxt;
      r_s_ready   <= (w_fill_nxt < DEPTH_L);
      r_dac_valid <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_dac_data <= w_head;
      end
      if (w_starve)         r_underrun <= 1'b1;
      else if (clear_flags) r_underrun <= 1'b0;

      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_PRIME;
            r_cnt   <= '0;
          end
          S_PRIME: begin
            r_cnt <= '0;
            if (r_fill >= PRIME_L) begin
              r_state   <= S_RUN;
              r_div_eff <= w_div_in;
            end
          end
          S_RUN: begin
            if (w_starve) begin
              r_state <= S_PRIME;
              r_cnt   <= '0;
            end else if (w_tick) begin
              r_cnt     <= '0;
              r_div_eff <= w_div_in;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign s_ready    = r_s_ready;
  assign dac_data   = r_dac_data;
  assign dac_valid  = r_dac_valid;
  assign underrun   = r_underrun;
  assign fill_level = r_fill;

endmodule

// File: tb/tb_dac_stream_pacer.sv
// Directed bench for dac_stream_pacer: priming, pacing, underrun, full FIFO, divisor change, mid-stream reset.
module tb_dac_stream_pacer;

  logic        CLK_65 = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] divisor;
  logic        clear_flags;
  logic [13:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [13:0] dac_data;
  logic        dac_valid;
  logic        underrun;
  logic [8:0]  fill_level;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK_65 = ~CLK_65;

  dac_stream_pacer dut (
    .CLK_65      (CLK_65),
    .reset_n     (reset_n),
    .enable      (enable),
    .divisor     (divisor),
    .clear_flags (clear_flags),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .dac_data    (dac_data),
    .dac_valid   (dac_valid),
    .underrun    (underrun),
    .fill_level  (fill_level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] exp_out(input logic [13:0] x);
`ifdef DAC_STREAM_PACER_SIGNED_IN_EN
    return x ^ 14'h2000;
`else
    return x;
`endif
  endfunction

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK_65);
      #1;
    end
  endtask

  // counts edges until dac_valid is seen, giving up after bound edges
  task automatic wait_strobe(input int bound, output int n);
    n = 0;
    do begin
      @(posedge CLK_65);
      #1;
      n++;
    end while (!dac_valid && n < bound);
    chk("strobe_seen", dac_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int wd;
    int expd;
    int cnt;

    reset_n = 1'b0; enable = 1'b0; divisor = 16'd4; clear_flags = 1'b0;
    s_data = '0; s_valid = 1'b0;
    #12;
    chk("rst_data",   dac_data, 8192);
    chk("rst_valid",  dac_valid, 0);
    chk("rst_under",  underrun, 0);
    chk("rst_ready",  s_ready, 0);
    chk("rst_fill",   fill_level, 0);
    #5 reset_n = 1'b1;
    step(1);
    chk("ready_rise", s_ready, 1);

    // prime with 100..107 at divisor 4
    enable = 1'b1; divisor = 16'd4; s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 14'(100 + i);
      step(1);
    end
    s_valid = 1'b0;
    chk("prime_fill", fill_level, 8);
    wait_strobe(50, n);
    chk("first_lat", n, 5);
    chk("d0", dac_data, exp_out(14'd100));
    step(1);
    chk("valid_pulse", dac_valid, 0);
    wait_strobe(20, n);
    chk("gap1", n, 3);
    chk("d1", dac_data, exp_out(14'd101));
    for (int k = 2; k < 8; k++) begin
      wait_strobe(20, n);
      chk("gap4", n, 4);
      chk("dk", dac_data, exp_out(14'(100 + k)));
    end
    step(3);
    chk("pre_under", underrun, 0);
    step(1);
    chk("under_set",   underrun, 1);
    chk("under_hold",  dac_data, exp_out(14'd107));
    chk("under_valid", dac_valid, 0);
    chk("under_fill",  fill_level, 0);
    clear_flags = 1'b1;
    step(1);
    clear_flags = 1'b0;
    chk("under_clr", underrun, 0);
    step(10);
    chk("prime_quiet", underrun, 0);
    chk("prime_novalid", dac_valid, 0);

    // divisor 0 with continuous feed from PRIME
    divisor = 16'd0; s_valid = 1'b1; wd = 200; s_data = 14'(wd); expd = 200;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      wd++;
      s_data = 14'(wd);
      if (c >= 10) begin
        chk("cont_valid", dac_valid, 1);
        chk("cont_fill",  fill_level, 9);
        chk("cont_data",  dac_data, exp_out(14'(expd)));
        expd++;
      end
    end

    // asynchronous reset mid-stream
    #3;
    reset_n = 1'b0; s_valid = 1'b0; enable = 1'b0;
    #1;
    chk("mid_rst_fill",  fill_level, 0);
    chk("mid_rst_data",  dac_data, 8192);
    chk("mid_rst_valid", dac_valid, 0);
    chk("mid_rst_ready", s_ready, 0);
    #3 reset_n = 1'b1;
    step(1);
    chk("ready_rise2", s_ready, 1);

    // fill to 16 while disabled, 17th offer dropped
    s_valid = 1'b1; s_data = 14'd300;
    for (int i = 1; i <= 17; i++) begin
      step(1);
      s_data = 14'(300 + i);
    end
    s_valid = 1'b0;
    chk("full_fill",  fill_level, 16);
    chk("full_ready", s_ready, 0);
    divisor = 16'd2; enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_strobe(40, n);
      chk("full_gap",  n, (k == 0) ? 4 : 2);
      chk("full_data", dac_data, exp_out(14'(300 + k)));
    end
    clear_flags = 1'b1;
    step(2);
    chk("set_wins",    underrun, 1);
    chk("full_novalid", dac_valid, 0);
    chk("full_hold",   dac_data, exp_out(14'd315));
    step(1);
    chk("clr_after",   underrun, 0);
    clear_flags = 1'b0;
    cnt = 0;
    repeat (10) begin
      step(1);
      if (dac_valid) cnt++;
    end
    chk("extra_strobes", cnt, 0);

    // divisor 4 -> 2 mid-period
    divisor = 16'd4; s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = (i == 0) ? 14'h2000 : 14'(400 + i);
      step(1);
    end
    s_valid = 1'b0;
    wait_strobe(50, n);
    chk("div_lat",  n, 5);
    chk("div_d0",   dac_data, exp_out(14'h2000));
    divisor = 16'd2;
    wait_strobe(20, n);
    chk("div_gap4", n, 4);
    chk("div_d1",   dac_data, exp_out(14'd401));
    wait_strobe(20, n);
    chk("div_gap2a", n, 2);
    chk("div_d2",   dac_data, exp_out(14'd402));
    wait_strobe(20, n);
    chk("div_gap2b", n, 2);
    chk("div_d3",   dac_data, exp_out(14'd403));

    // disable: strobe stops, data and FIFO retained
    enable = 1'b0;
    step(1);
    chk("dis_valid", dac_valid, 0);
    chk("dis_data",  dac_data, exp_out(14'd403));
    chk("dis_fill",  fill_level, 4);
    step(5);
    chk("dis_fill2", fill_level, 4);
    chk("dis_under", underrun, 0);
    chk("dis_quiet", dac_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
